// File: rtl/gpu_pkg.sv
// Shared GPU encodings: program-memory channel states and core pipeline states.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        READ_WAITING = 2'b01,
        RELAYING     = 2'b10
    } channel_state_t;

    typedef enum logic [2:0] {
        FETCH  = 3'b001,
        DECODE = 3'b010
    } core_state_t;

endpackage

// File: rtl/consumer_picker.sv
// Picks the lowest-index consumer that is requesting and not blocked.
// Latency: combinational; backpressure: none, blocked consumers are simply skipped.
module consumer_picker #(
    parameter int NUM_CONSUMERS = 4
) (
    input  logic [NUM_CONSUMERS-1:0] valid,
    input  logic [NUM_CONSUMERS-1:0] blocked,
    output logic [NUM_CONSUMERS-1:0] pick_onehot,
    output logic                     found
);

    logic hit;

    always_comb begin
        pick_onehot = '0;
        hit         = 1'b0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (valid[i] && !blocked[i] && !hit) begin
                pick_onehot[i] = 1'b1;
                hit            = 1'b1;
            end
        end
        found = hit;
    end

endmodule

// File: rtl/program_mem_controller.sv
// Shares NUM_CHANNELS program-memory read ports among NUM_CONSUMERS fetchers.
// Latency: request -> mem_read_valid 1 cycle, mem_read_ready -> consumer_read_ready 1 cycle;
// backpressure: a fetcher holds valid until served, a channel holds its claim until valid drops.
module program_mem_controller
    import gpu_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    channel_state_t      state_q [NUM_CHANNELS];
    channel_state_t      state_d [NUM_CHANNELS];
    logic [IDX_BITS-1:0] owner_q [NUM_CHANNELS];
    logic [IDX_BITS-1:0] ch_idx  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  ch_found;
    logic [NUM_CONSUMERS-1:0] claimed;

    // A channel keeps its consumer claimed up to and including its release cycle.
    always_comb begin
        claimed = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] != IDLE) claimed[owner_q[c]] = 1'b1;
        end
    end

    // Channel c sees everything already claimed plus what lower channels pick this cycle.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] blk_in;
        logic [NUM_CONSUMERS-1:0] blk_out;
        logic [NUM_CONSUMERS-1:0] cand;
        logic [NUM_CONSUMERS-1:0] pick;
        logic                     found;
        logic [IDX_BITS-1:0]      idx;

        if (c == 0) begin : g_first
            assign blk_in = claimed;
        end else begin : g_rest
            assign blk_in = g_ch[c-1].blk_out;
        end

        assign cand = consumer_read_valid & {NUM_CONSUMERS{state_q[c] == IDLE}};

        consumer_picker #(.NUM_CONSUMERS(NUM_CONSUMERS)) u_picker (
            .valid       (cand),
            .blocked     (blk_in),
            .pick_onehot (pick),
            .found       (found)
        );

        assign blk_out = blk_in | pick;

        always_comb begin
            idx = '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                if (pick[i]) idx = i[IDX_BITS-1:0];
            end
        end

        assign ch_found[c] = found;
        assign ch_idx[c]   = idx;
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                IDLE:         if (ch_found[c]) state_d[c] = READ_WAITING;
                READ_WAITING: if (mem_read_ready[c]) state_d[c] = RELAYING;
                RELAYING:     if (!consumer_read_valid[owner_q[c]]) state_d[c] = IDLE;
                default:      state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (reset) state_q[c] <= IDLE;
            else       state_q[c] <= state_d[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) owner_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state_q[c])
                    IDLE: begin
                        if (ch_found[c]) begin
                            mem_read_valid[c]   <= 1'b1;
                            mem_read_address[c] <= consumer_read_address[ch_idx[c]];
                            owner_q[c]          <= ch_idx[c];
                        end
                    end
                    READ_WAITING: begin
                        if (mem_read_ready[c]) begin
                            mem_read_valid[c]                <= 1'b0;
                            consumer_read_ready[owner_q[c]]  <= 1'b1;
                            consumer_read_data[owner_q[c]]   <= mem_read_data[c];
                        end
                    end
                    RELAYING: begin
                        // Data is left in place after the handshake completes.
                        if (!consumer_read_valid[owner_q[c]])
                            consumer_read_ready[owner_q[c]] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/program_mem_controller.md
PROGRAM_MEM_CONTROLLER -- requirements
Module: program_mem_controller

Interface
REQ-001 Parameter NUM_CONSUMERS, default 4, SHALL set the number of fetchers served (one per core).
REQ-002 Parameter NUM_CHANNELS, default 1, SHALL set the number of concurrent program-memory read channels.
REQ-003 Parameter ADDR_BITS, default 8, SHALL set the program address width.
REQ-004 Parameter DATA_BITS, default 16, SHALL set the instruction width.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be synchronous and active-high.
REQ-007 consumer_read_valid  input  [NUM_CONSUMERS]  SHALL carry per-fetcher read request, held until served.
REQ-008 consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  SHALL carry per-fetcher address, stable while valid.
REQ-009 consumer_read_ready  output  [NUM_CONSUMERS]  SHALL pulse a per-fetcher response-valid flag.
REQ-010 consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  SHALL carry per-fetcher instruction, valid while ready high.
REQ-011 mem_read_valid  output  [NUM_CHANNELS]  SHALL carry per-channel memory request.
REQ-012 mem_read_address  output  [NUM_CHANNELS][ADDR_BITS]  SHALL carry per-channel memory address.
REQ-013 mem_read_ready  input  [NUM_CHANNELS]  SHALL indicate memory response on that channel.
REQ-014 mem_read_data  input  [NUM_CHANNELS][DATA_BITS]  SHALL carry memory data, valid with mem_read_ready.

Function
REQ-015 Each channel SHALL run an FSM: IDLE, READ_WAITING, RELAYING.
REQ-016 IDLE: channel SHALL claim the lowest-index consumer with valid high and not claimed by any channel; set mem_read_valid=1, mem_read_address=that consumer's address; go READ_WAITING; no claim -> stay IDLE.
REQ-017 Same-cycle claims SHALL resolve channel 0 first; a consumer claimed by a lower channel that cycle SHALL NOT be claimed by a higher one.
REQ-018 READ_WAITING: on mem_read_ready, channel SHALL clear mem_read_valid, set consumer_read_ready=1 and consumer_read_data=mem_read_data for the claimed consumer, go RELAYING; otherwise hold all outputs.
REQ-019 RELAYING: when claimed consumer's valid is low, channel SHALL clear that consumer_read_ready, release the claim, go IDLE; while valid stays high, hold ready and data.
REQ-020 Minimum latency SHALL be: request seen cycle N -> mem_read_valid at N+1; mem_read_ready at cycle M -> consumer_read_ready at M+1.
REQ-021 A released channel SHALL NOT claim in its release cycle; earliest new claim is the following cycle in IDLE.
REQ-022 consumer_read_data SHALL hold its last value after ready drops (no clearing).
REQ-023 At most one channel SHALL ever claim a given consumer; at most one outstanding request per channel.
REQ-024 Arbitration SHALL be fixed-priority by consumer index; no starvation protection required.

Reset
REQ-025 On reset all channels SHALL enter IDLE with all claims released.
REQ-026 On reset mem_read_valid, mem_read_address, consumer_read_ready, consumer_read_data SHALL all be 0.
REQ-027 Reset mid-transaction SHALL abandon it; a mem_read_ready arriving after reset SHALL be ignored by IDLE channels.

Structure
REQ-028 Channel-state encodings (IDLE=2'b00, READ_WAITING=2'b01, RELAYING=2'b10) and core-state encodings (FETCH=3'b001, DECODE=3'b010) SHALL live in the shared package gpu_pkg.
REQ-029 One combinational sub-module, consumer_picker (lowest-index valid and unclaimed consumer; one-hot plus found flag), SHALL be used. Claim bookkeeping stays in the top.

Verification
REQ-030 Single request: consumer 2 valid, addr 0x1A; memory ready 3 cycles later with 0xBEEF -> mem_read_address=0x1A, consumer_read_data[2]=0xBEEF, ready[2] one cycle after mem ready.
REQ-031 Contention, 1 channel: consumers 0,1,3 valid same cycle -> served in order 0,1,3; mem_read_valid never asserted for two consumers at once.
REQ-032 Two channels, consumers 0 and 1 valid same cycle -> channel 0 takes consumer 0, channel 1 takes consumer 1, both mem_read_valid high next cycle.
REQ-033 Consumer holds valid 4 cycles after ready -> ready[i] and data held 4 cycles, channel stays RELAYING, no new mem request.
REQ-034 Reset asserted in READ_WAITING, mem_read_ready pulses next cycle -> all outputs 0, no consumer_read_ready.
REQ-035 Back-to-back: consumer 0 re-requests 0x05 one cycle after dropping valid -> new mem request issued, data 0x1234 relayed correctly.
